// File: rtl/ysyx_220066_load_rsp.sv
// Load-response unit: takes one load from the memory stage, issues an aligned
// 64-bit bus read, then extracts and extends the addressed bytes. The result
// is returned to writeback as a single-cycle registered pulse.
module ysyx_220066_load_rsp #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [63:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic        flush,
    output logic        bus_ar_valid,
    input  logic        bus_ar_ready,
    output logic [63:0] bus_addr,
    input  logic        bus_r_valid,
    input  logic [63:0] bus_r_data,
    input  logic        bus_r_err,
    output logic [63:0] data_Rd,
    output logic        data_Rd_valid,
    output logic        data_Rd_error
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

    localparam logic [7:0] TO_CNT = 8'(TIMEOUT);

    state_t      state_q, state_d;
    logic        killed_q, killed_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [2:0]  off_q, off_d;
    logic [63:0] bus_addr_q, bus_addr_d;
    logic [63:0] rd_data_q, rd_data_d;
    logic        rd_valid_q, rd_valid_d;
    logic        rd_err_q, rd_err_d;

    logic        misaligned;
    logic        kill;
    logic [7:0]  cnt_inc;
    logic [63:0] sh;
    logic [63:0] ext;

    assign req_ready     = (state_q == IDLE) && !flush;
    assign bus_ar_valid  = (state_q == ADDR);
    assign bus_addr      = bus_addr_q;
    assign data_Rd       = rd_data_q;
    assign data_Rd_valid = rd_valid_q;
    assign data_Rd_error = rd_err_q;

    // Alignment check on the incoming request and byte extraction of read data
    always_comb begin
        misaligned = 1'b0;
        case (req_size)
            2'd1:    misaligned = req_addr[0];
            2'd2:    misaligned = (req_addr[1:0] != 2'b00);
            2'd3:    misaligned = (req_addr[2:0] != 3'b000);
            default: misaligned = 1'b0;
        endcase

        sh = bus_r_data >> {off_q, 3'b000};
        case (size_q)
            2'd0:    ext = uns_q ? {56'b0, sh[7:0]}  : {{56{sh[7]}},  sh[7:0]};
            2'd1:    ext = uns_q ? {48'b0, sh[15:0]} : {{48{sh[15]}}, sh[15:0]};
            2'd2:    ext = uns_q ? {32'b0, sh[31:0]} : {{32{sh[31]}}, sh[31:0]};
            default: ext = sh;
        endcase
    end

    // Next-state logic; result registers hold data and drop valid/error by default
    always_comb begin
        state_d    = state_q;
        killed_d   = killed_q;
        cnt_d      = cnt_q;
        size_d     = size_q;
        uns_d      = uns_q;
        off_d      = off_q;
        bus_addr_d = bus_addr_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        rd_err_d   = 1'b0;
        kill       = killed_q || flush;
        cnt_inc    = cnt_q + 8'd1;

        case (state_q)
            IDLE: begin
                killed_d = 1'b0;
                if (req_valid && req_ready) begin
                    size_d = req_size;
                    uns_d  = req_unsigned;
                    off_d  = req_addr[2:0];
                    if (misaligned) begin
                        state_d    = RESP;
                        rd_valid_d = 1'b1;
                        rd_err_d   = 1'b1;
                        rd_data_d  = 64'd0;
                    end else begin
                        state_d    = ADDR;
                        bus_addr_d = {req_addr[63:3], 3'b000};
                    end
                end
            end
            ADDR: begin
                // A flush here still lets the address handshake finish
                if (flush) killed_d = 1'b1;
                if (bus_ar_ready) begin
                    state_d = DATA;
                    cnt_d   = 8'd0;
                end
            end
            DATA: begin
                killed_d = kill;
                if (bus_r_valid) begin
                    if (kill) begin
                        state_d  = IDLE;
                        killed_d = 1'b0;
                    end else begin
                        state_d    = RESP;
                        rd_valid_d = 1'b1;
                        rd_err_d   = bus_r_err;
                        rd_data_d  = ext;
                    end
                end else if (cnt_inc == TO_CNT) begin
                    if (kill) begin
                        state_d  = IDLE;
                        killed_d = 1'b0;
                    end else begin
                        state_d    = RESP;
                        rd_valid_d = 1'b1;
                        rd_err_d   = 1'b1;
                        rd_data_d  = 64'd0;
                    end
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                // RESP: the pulse is already on the outputs; writeback owns any flush
                state_d  = IDLE;
                killed_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            killed_q   <= 1'b0;
            cnt_q      <= 8'd0;
            size_q     <= 2'd0;
            uns_q      <= 1'b0;
            off_q      <= 3'd0;
            bus_addr_q <= 64'd0;
            rd_data_q  <= 64'd0;
            rd_valid_q <= 1'b0;
            rd_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            killed_q   <= killed_d;
            cnt_q      <= cnt_d;
            size_q     <= size_d;
            uns_q      <= uns_d;
            off_q      <= off_d;
            bus_addr_q <= bus_addr_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            rd_err_q   <= rd_err_d;
        end
    end

endmodule

// File: tb/tb_ysyx_220066_load_rsp.sv
// Directed bench for the load-response unit (TIMEOUT set to 4).
module tb_ysyx_220066_load_rsp;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_addr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic        flush;
    logic        bus_ar_valid;
    logic        bus_ar_ready;
    logic [63:0] bus_addr;
    logic        bus_r_valid;
    logic [63:0] bus_r_data;
    logic        bus_r_err;
    logic [63:0] data_Rd;
    logic        data_Rd_valid;
    logic        data_Rd_error;

    int vecs = 0;
    int errs = 0;

    ysyx_220066_load_rsp #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_size(req_size), .req_unsigned(req_unsigned), .flush(flush),
        .bus_ar_valid(bus_ar_valid), .bus_ar_ready(bus_ar_ready), .bus_addr(bus_addr),
        .bus_r_valid(bus_r_valid), .bus_r_data(bus_r_data), .bus_r_err(bus_r_err),
        .data_Rd(data_Rd), .data_Rd_valid(data_Rd_valid), .data_Rd_error(data_Rd_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept at T, address handshake after arw stall cycles, data next cycle
    task automatic run_load(input string tag, input logic [63:0] a, input logic [1:0] sz,
                            input logic u, input int arw, input logic [63:0] rd,
                            input logic re, input logic [63:0] ed, input logic ee);
        logic [63:0] ba;
        ba = {a[63:3], 3'b000};
        req_valid = 1'b1; req_addr = a; req_size = sz; req_unsigned = u;
        #1 chk({tag, ".ready"}, 64'(req_ready), 64'd1);
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < arw; i++) begin
            chk({tag, ".ar_stall"}, 64'(bus_ar_valid), 64'd1);
            chk({tag, ".addr_stall"}, bus_addr, ba);
            tick();
        end
        chk({tag, ".ar_valid"}, 64'(bus_ar_valid), 64'd1);
        chk({tag, ".addr"}, bus_addr, ba);
        bus_ar_ready = 1'b1;
        tick();
        bus_ar_ready = 1'b0;
        chk({tag, ".ar_drop"}, 64'(bus_ar_valid), 64'd0);
        bus_r_valid = 1'b1; bus_r_data = rd; bus_r_err = re;
        tick();
        bus_r_valid = 1'b0; bus_r_err = 1'b0;
        chk({tag, ".valid"}, 64'(data_Rd_valid), 64'd1);
        chk({tag, ".err"}, 64'(data_Rd_error), 64'(ee));
        chk({tag, ".data"}, data_Rd, ed);
        tick();
        chk({tag, ".valid_off"}, 64'(data_Rd_valid), 64'd0);
        chk({tag, ".err_off"}, 64'(data_Rd_error), 64'd0);
        chk({tag, ".data_hold"}, data_Rd, ed);
    endtask

    // Misaligned load: no bus read, error pulse the next cycle
    task automatic run_misaligned(input string tag, input logic [63:0] a, input logic [1:0] sz);
        req_valid = 1'b1; req_addr = a; req_size = sz; req_unsigned = 1'b0;
        tick();
        req_valid = 1'b0;
        chk({tag, ".no_ar"}, 64'(bus_ar_valid), 64'd0);
        chk({tag, ".valid"}, 64'(data_Rd_valid), 64'd1);
        chk({tag, ".err"}, 64'(data_Rd_error), 64'd1);
        chk({tag, ".data"}, data_Rd, 64'd0);
        tick();
        chk({tag, ".valid_off"}, 64'(data_Rd_valid), 64'd0);
        chk({tag, ".ready"}, 64'(req_ready), 64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; req_valid = 1'b0; req_addr = '0; req_size = '0; req_unsigned = 1'b0;
        flush = 1'b0; bus_ar_ready = 1'b0; bus_r_valid = 1'b0; bus_r_data = '0; bus_r_err = 1'b0;
        tick(); tick();
        chk("rst.valid", 64'(data_Rd_valid), 64'd0);
        chk("rst.err", 64'(data_Rd_error), 64'd0);
        chk("rst.data", data_Rd, 64'd0);
        chk("rst.ar_valid", 64'(bus_ar_valid), 64'd0);
        chk("rst.addr", bus_addr, 64'd0);
        rst = 1'b1;
        tick();
        chk("rst.ready", 64'(req_ready), 64'd1);

        run_load("lb", 64'h8000_0005, 2'd0, 1'b0, 0, 64'h0000_80FF_0000_0000, 1'b0,
                 64'hFFFF_FFFF_FFFF_FF80, 1'b0);
        run_load("lbu", 64'h8000_0005, 2'd0, 1'b1, 0, 64'h0000_80FF_0000_0000, 1'b0,
                 64'h0000_0000_0000_0080, 1'b0);
        run_load("lwu", 64'h8000_0004, 2'd2, 1'b1, 0, 64'h8765_4321_DEAD_BEEF, 1'b0,
                 64'h0000_0000_8765_4321, 1'b0);
        run_load("lw", 64'h8000_0004, 2'd2, 1'b0, 0, 64'h8765_4321_DEAD_BEEF, 1'b0,
                 64'hFFFF_FFFF_8765_4321, 1'b0);
        run_load("lh", 64'h8000_0006, 2'd1, 1'b0, 0, 64'h8765_4321_DEAD_BEEF, 1'b0,
                 64'hFFFF_FFFF_FFFF_8765, 1'b0);
        run_load("lhu0", 64'h8000_0000, 2'd1, 1'b1, 0, 64'h8765_4321_DEAD_BEEF, 1'b0,
                 64'h0000_0000_0000_BEEF, 1'b0);
        run_load("ld", 64'h8000_0008, 2'd3, 1'b1, 0, 64'hFEDC_BA98_7654_3210, 1'b0,
                 64'hFEDC_BA98_7654_3210, 1'b0);
        run_load("buserr", 64'h0000_0010, 2'd3, 1'b0, 3, 64'h1122_3344_5566_7788, 1'b1,
                 64'h1122_3344_5566_7788, 1'b1);

        run_misaligned("mis_h", 64'h8000_0003, 2'd1);
        run_misaligned("mis_w", 64'h8000_0002, 2'd2);
        run_misaligned("mis_d", 64'h8000_0004, 2'd3);

        // Flush in IDLE blocks acceptance
        flush = 1'b1; req_valid = 1'b1; req_addr = 64'h100; req_size = 2'd3;
        #1 chk("fl_idle.ready", 64'(req_ready), 64'd0);
        tick();
        flush = 1'b0; req_valid = 1'b0;
        chk("fl_idle.no_ar", 64'(bus_ar_valid), 64'd0);

        // Flush in DATA, then read data: no result, then a normal load
        req_valid = 1'b1; req_addr = 64'h8000_0000; req_size = 2'd2; req_unsigned = 1'b0;
        tick();
        req_valid = 1'b0; bus_ar_ready = 1'b1;
        tick();
        bus_ar_ready = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0; bus_r_valid = 1'b1; bus_r_data = 64'h0000_0000_1234_5678;
        tick();
        bus_r_valid = 1'b0;
        chk("fl_data.no_valid", 64'(data_Rd_valid), 64'd0);
        chk("fl_data.ready", 64'(req_ready), 64'd1);
        run_load("after_fl", 64'h8000_0000, 2'd2, 1'b0, 0, 64'h0000_0000_1234_5678, 1'b0,
                 64'h0000_0000_1234_5678, 1'b0);

        // Flush in ADDR: handshake still completes, result suppressed
        req_valid = 1'b1; req_addr = 64'h8000_0018; req_size = 2'd3;
        tick();
        req_valid = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl_addr.ar_held", 64'(bus_ar_valid), 64'd1);
        bus_ar_ready = 1'b1;
        tick();
        bus_ar_ready = 1'b0; bus_r_valid = 1'b1; bus_r_data = 64'hAAAA_BBBB_CCCC_DDDD;
        tick();
        bus_r_valid = 1'b0;
        chk("fl_addr.no_valid", 64'(data_Rd_valid), 64'd0);
        chk("fl_addr.data_hold", data_Rd, 64'h0000_0000_1234_5678);

        // Timeout: accept at T, ar_ready at T+1, error pulse at T+6
        req_valid = 1'b1; req_addr = 64'h40; req_size = 2'd3;
        tick();
        req_valid = 1'b0; bus_ar_ready = 1'b1;
        tick();
        bus_ar_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("to.wait", 64'(data_Rd_valid), 64'd0);
            tick();
        end
        chk("to.valid", 64'(data_Rd_valid), 64'd1);
        chk("to.err", 64'(data_Rd_error), 64'd1);
        chk("to.data", data_Rd, 64'd0);
        tick();
        chk("to.valid_off", 64'(data_Rd_valid), 64'd0);

        // Load leaving nonzero data, then reset during DATA of the next load
        run_load("pre_rst", 64'h8000_0001, 2'd0, 1'b1, 0, 64'h0000_0000_0000_5A00, 1'b0,
                 64'h0000_0000_0000_005A, 1'b0);
        req_valid = 1'b1; req_addr = 64'h8000_0020; req_size = 2'd3;
        tick();
        req_valid = 1'b0; bus_ar_ready = 1'b1;
        tick();
        bus_ar_ready = 1'b0; rst = 1'b0;
        tick();
        chk("mrst.ar_valid", 64'(bus_ar_valid), 64'd0);
        chk("mrst.addr", bus_addr, 64'd0);
        chk("mrst.data", data_Rd, 64'd0);
        chk("mrst.valid", 64'(data_Rd_valid), 64'd0);
        chk("mrst.err", 64'(data_Rd_error), 64'd0);
        rst = 1'b1; bus_r_valid = 1'b1; bus_r_data = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        bus_r_valid = 1'b0;
        tick();
        chk("mrst.late_r", 64'(data_Rd_valid), 64'd0);
        chk("mrst.ready", 64'(req_ready), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/ysyx_220066_load_rsp.md
# ysyx_220066_load_rsp

Load-response unit for the RV64 pipeline. It accepts one load request at a time from the memory stage and issues an aligned 64-bit read on the data bus. It extracts and sign- or zero-extends the addressed bytes, then drives `data_Rd`/`data_Rd_valid`/`data_Rd_error` to the writeback stage. Writeback stalls its memory slot (`m_block`) until `data_Rd_valid` pulses, so this block is the producing end of that handshake.

## Interface
- `TIMEOUT`, 255: bus cycles to wait for read data before reporting a bus error (8-bit counter, 1..255).
- `clk` in 1: clock, all state on rising edge.
- `rst` in 1: synchronous, active-low reset (`rst==0` resets).
- `req_valid` in 1: memory stage presents a load.
- `req_ready` out 1: block can accept a load.
- `req_addr` in 64: byte address.
- `req_size` in 2: 0=byte, 1=half, 2=word, 3=dword.
- `req_unsigned` in 1: 1 selects zero-extend (LBU/LHU/LWU), 0 selects sign-extend.
- `flush` in 1: kill the in-flight load; its result is never delivered.
- `bus_ar_valid` out 1: read-address valid.
- `bus_ar_ready` in 1: bus accepts the address.
- `bus_addr` out 64: `{req_addr[63:3],3'b0}`.
- `bus_r_valid` in 1: read data valid.
- `bus_r_data` in 64: read data.
- `bus_r_err` in 1: bus error with the data.
- `data_Rd` out 64: extended load result.
- `data_Rd_valid` out 1: one-cycle result pulse to writeback.
- `data_Rd_error` out 1: result is an error (misaligned, bus error, or timeout); qualified by `data_Rd_valid`.

## Operation
- FSM states: IDLE, ADDR, DATA, RESP.
- `req_ready = (state==IDLE) && !flush`. A request is accepted on `req_valid && req_ready`. Accepting latches the address, size, unsigned flag, and `addr[2:0]`.
- Misalignment check at accept: size1 with `addr[0]`, size2 with `addr[1:0]!=0`, or size3 with `addr[2:0]!=0`.
  - Misaligned: IDLE→RESP with error=1 and data=0. No bus transaction is made.
  - Aligned: IDLE→ADDR.
- ADDR: `bus_ar_valid=1`. Leave on `bus_ar_ready`: go to DATA and clear the timeout counter. `bus_ar_valid` and `bus_addr` stay stable until the handshake.
- DATA: wait for `bus_r_valid`, then go to RESP.
  - On entering RESP, latch the extracted data and error=`bus_r_err`.
  - Each DATA cycle without `bus_r_valid` increments the counter.
  - When the counter reaches `TIMEOUT`: go to RESP with error=1 and data=0.
- RESP: `data_Rd_valid=1` for exactly one cycle, then go to IDLE. Writeback consumes the result unconditionally in that cycle; there is no back-pressure.
- Extraction: `sh = bus_r_data >> (8*off)`.
  - size0: `sh[7:0]`; size1: `sh[15:0]`; size2: `sh[31:0]`; size3: `sh`.
  - Extend to 64 bits: zero-extend if `req_unsigned`, otherwise sign-extend. size3 ignores `req_unsigned`.
- Flush sets a `killed` flag.
  - In IDLE: no effect (the request that cycle is not accepted).
  - In ADDR: the address handshake still completes. After that the block goes to DATA with `killed` set.
  - In DATA with `killed` set: on `bus_r_valid` or timeout, go to IDLE with no `data_Rd_valid`.
  - In RESP: `data_Rd_valid` is not retracted that cycle. Writeback owns flush of its own slot.
- `killed` clears on entry to IDLE.
- Outputs `data_Rd`, `data_Rd_valid`, and `data_Rd_error` are registered. When not valid, `data_Rd` holds its last value and `data_Rd_error` is 0.

## Timing
- Reset (`rst==0` at an edge):
  - state=IDLE, killed=0, counter=0.
  - `bus_ar_valid=0`, `bus_addr=0`, `data_Rd=0`, `data_Rd_valid=0`, `data_Rd_error=0`.
  - `req_ready` becomes 1 the cycle after reset deasserts, unless `flush` is high.
- Reset mid-transaction abandons the transaction. A `bus_r_valid` arriving after reset is ignored, because the block is in IDLE.
- Aligned load, accepted at cycle T:
  - `bus_ar_valid` is high from T+1.
  - `bus_ar_ready` at T+1 → DATA at T+2.
  - `bus_r_valid` at T+2 → `data_Rd_valid` at T+3 (minimum latency 3).
- Misaligned load accepted at T → `data_Rd_valid=1` with error=1 at T+1.
- Timeout: with `bus_ar_ready` at T+1 and no read data, the error pulse arrives at T+2+`TIMEOUT`.
- Back-to-back: the next request can be accepted in the cycle after RESP (IDLE), so the throughput limit is one load per 4 cycles at minimum latency.
- `bus_r_valid` outside DATA is ignored.

## Test plan
- Sign-extended byte: `addr=0x80000005`, size0, signed, `r_data=0x0000_80FF_0000_0000` → `data_Rd=0xFFFF_FFFF_FFFF_FF80` with valid at T+3 and error=0.
- Zero-extended word: `addr=0x80000004`, size2, unsigned, `r_data=0x8765_4321_xxxx_xxxx` → `data_Rd=0x0000_0000_8765_4321`.
- Misaligned half: `addr=0x80000003`, size1 → no `bus_ar_valid`; valid and error=1 at T+1 with `data_Rd=0`.
- Address back-pressure and bus error: `bus_ar_ready` low for 3 cycles with `bus_addr` stable, then `r_valid` with `r_err=1` → single valid pulse with error=1.
- Flush in DATA, then `r_valid` → no `data_Rd_valid`, back to IDLE. A new request the next cycle completes normally.
- Timeout with `TIMEOUT=4` and `r_valid` never asserted → error pulse at T+6. `rst=0` asserted in DATA → all outputs 0 on the next cycle.
